// File: rtl/prod_bcd_converter.sv
// prod_bcd_converter
//   Sequential binary-to-BCD converter (shift-and-add-3). Takes the IN_W-bit
//   multiplier product and produces DIGITS packed BCD digits for the
//   7-segment driver. One conversion at a time, start/done handshake.
//   The result is held until the next conversion completes.
// Ports
//   clk    rising-edge clock
//   reset  asynchronous active-low reset
//   start  conversion request, sampled only in IDLE
//   bin    binary input, captured on the accepted-start edge
//   busy   high during the SHIFT cycles
//   done   one-cycle pulse, bcd has just been updated
//   bcd    packed BCD, [3:0] = units, [7:4] = tens, ...

// Per-digit add-3 adjust: a digit >= 5 would carry out past 9 after the
// following doubling, so pre-bias it by 3.
module prod_bcd_adj3 (
  input  logic [3:0] d,
  output logic [3:0] q
);
  assign q = (d >= 4'd5) ? d + 4'd3 : d;
endmodule

module prod_bcd_converter #(
  parameter int IN_W   = 8,
  parameter int DIGITS = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [IN_W-1:0]       bin,
  output logic                  busy,
  output logic                  done,
  output logic [4*DIGITS-1:0]   bcd
);
  localparam int SW = 4*DIGITS;
  localparam int CW = $clog2(IN_W+1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t          state;
  logic [IN_W-1:0] shreg;
  logic [SW-1:0]   scratch;
  logic [SW-1:0]   adj;
  logic [SW-1:0]   scratch_nxt;
  logic [CW-1:0]   count;

  // adjust every digit, then shift {adj, shreg} left by one
  for (genvar g = 0; g < DIGITS; g++) begin : g_dig
    prod_bcd_adj3 u_adj (
      .d (scratch[4*g +: 4]),
      .q (adj[4*g +: 4])
    );
  end

  assign scratch_nxt = {adj[SW-2:0], shreg[IN_W-1]};

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      shreg   <= '0;
      scratch <= '0;
      count   <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      bcd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            shreg   <= bin;
            scratch <= '0;
            count   <= CW'(IN_W);
            busy    <= 1'b1;
            state   <= SHIFT;
          end
        end
        SHIFT: begin
          scratch <= scratch_nxt;
          shreg   <= {shreg[IN_W-2:0], 1'b0};
          count   <= count - CW'(1);
          // last shift: publish the final scratch directly from the adjust path
          if (count == CW'(1)) begin
            bcd   <= scratch_nxt;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_prod_bcd_converter.sv
module tb_prod_bcd_converter;
  localparam int IN_W   = 8;
  localparam int DIGITS = 3;

  logic                clk = 1'b0;
  logic                reset = 1'b0;
  logic                start = 1'b0;
  logic [IN_W-1:0]     bin = '0;
  logic                busy;
  logic                done;
  logic [4*DIGITS-1:0] bcd;

  int checks   = 0;
  int failures = 0;

  prod_bcd_converter #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .start (start),
    .bin   (bin),
    .busy  (busy),
    .done  (done),
    .bcd   (bcd)
  );

  always #5 clk = ~clk;

  initial begin
    if (!(10**DIGITS > 2**IN_W - 1))
      $fatal(1, "FAIL digits_rule DIGITS=%0d too small for IN_W=%0d", DIGITS, IN_W);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
  endfunction

  // one full conversion from IDLE; checks latency, busy length, result,
  // single-cycle done and digit range
  task automatic run_conv(input logic [7:0] v, input logic [11:0] exp, input string tag);
    int lat;
    int busy_n;
    bit got;
    lat = 0; busy_n = 0; got = 0;
    bin = v; start = 1'b1;
    tick();                       // E0
    start = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      if (busy) busy_n++;
      if (done) got = 1;
      else begin
        tick();
        lat++;
      end
    end
    check({tag, "_done_seen"}, 32'(got), 32'd1);
    check({tag, "_latency"}, 32'(lat), 32'd8);
    check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
    check({tag, "_bcd"}, 32'(bcd), 32'(exp));
    check({tag, "_digit_range"},
          32'((bcd[3:0] <= 4'd9) && (bcd[7:4] <= 4'd9) && (bcd[11:8] <= 4'd9)), 32'd1);
    tick();
    check({tag, "_done_one_cycle"}, 32'(done), 32'd0);
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
  endtask

  initial begin
    int dn;
    int last;
    bit bad;

    // reset state
    #3;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_bcd", 32'(bcd), 32'd0);
    tick(); tick();
    reset = 1'b1;
    tick();

    // 1: basic
    run_conv(8'd63, 12'h063, "t1_63");

    // 2: extremes, bcd holds across IDLE
    run_conv(8'd255, 12'h255, "t2_255");
    tick(); tick(); tick();
    check("t2_hold_idle", 32'(bcd), 32'h255);
    run_conv(8'd0, 12'h000, "t2_0");

    // 3: start during busy ignored, bin change ignored
    bin = 8'd100; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick();
    bin = 8'd7; start = 1'b1;
    tick();
    start = 1'b0;
    dn = 0;
    for (int i = 0; i < 20; i++) begin
      if (done) dn++;
      tick();
    end
    check("t3_done_count", 32'(dn), 32'd1);
    check("t3_bcd", 32'(bcd), 32'h100);

    // 4: start held high -> done every 10 cycles
    bin = 8'd42; start = 1'b1;
    tick();                       // E0
    dn = 0; last = -1; bad = 0;
    for (int i = 0; i < 40; i++) begin
      if (done) begin
        if (dn == 0) begin
          if (i != 8) bad = 1;
        end else if (i - last != 10) bad = 1;
        if (bcd !== 12'h042) bad = 1;
        last = i;
        dn++;
      end
      if (i == 39) start = 1'b0;
      else tick();
    end
    check("t4_done_count", 32'(dn), 32'd4);
    check("t4_period_and_bcd", 32'(bad), 32'd0);
    tick(); tick(); tick();
    check("t4_idle_busy", 32'(busy), 32'd0);

    // 5: reset mid-conversion
    bin = 8'd199; start = 1'b1;
    tick();
    start = 1'b0;
    tick(); tick(); tick();
    reset = 1'b0;
    #1;
    check("t5_abort_busy", 32'(busy), 32'd0);
    check("t5_abort_done", 32'(done), 32'd0);
    check("t5_abort_bcd", 32'(bcd), 32'd0);
    tick(); tick();
    reset = 1'b1;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (done !== 1'b0 || busy !== 1'b0) bad = 1;
    end
    check("t5_no_done_after", 32'(bad), 32'd0);
    check("t5_bcd_zero", 32'(bcd), 32'd0);
    run_conv(8'd9, 12'h009, "t5_9");

    // 6: every 4x4 multiplier product, then the full 0..255 range
    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_conv(8'(a * b), to_bcd(a * b), "t6_prod");
    for (int v = 0; v < 256; v++)
      run_conv(8'(v), to_bcd(v), "t6_range");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
